mdu: RTL
========

# mdu

Iterative multiply/divide unit for the pipelined CPU's execute stage. It consumes the two operands read from the register file (RD1/RD2 via the ID/EX register) and computes MULT/MULTU/DIV/DIVU over 33 cycles into architectural HI/LO registers. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. The hazard unit stalls on `busy`.

## Interface
- Parameters: none. Data width is fixed at 32; the iteration count comes from the package.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-low.
- `start`  in  1  begin operation `op` on `a`/`b`. Sampled only in IDLE.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  32  operand / dividend (rs).
- `b`  in  32  operand / divisor (rt).
- `cancel`  in  1  abort the in-flight operation (pipeline flush).
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write strobes.
- `wd`  in  32  MTHI/MTLO write data.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO take a result.
- `hi`, `lo`  out  32 each  architectural HI/LO, registered.

## Operation
- States:
  - IDLE: `start` moves to CALC and latches op, sign flags, |a|, |b| (magnitudes only for signed ops), and clears the 6-bit count.
  - CALC: performs one iteration per cycle; at count == 31 it moves to FIX.
  - FIX: applies sign correction, writes HI/LO, pulses `done`, returns to IDLE.
- Multiply: shift-add over a 64-bit accumulator, one multiplier bit per cycle.
  - Result: hi = product[63:32], lo = product[31:0].
  - Signed: the 64-bit product is negated when a[31]^b[31].
- Divide: restoring, one quotient bit per cycle, using a 33-bit partial remainder.
  - Result: lo = quotient, hi = remainder.
  - Signed: the quotient is negated when a[31]^b[31]; the remainder takes the sign of a.
  - 0x80000000 / -1 gives lo = 0x80000000, hi = 0, with no trap.
- Divide by zero: lo = 0xFFFFFFFF, hi = a (original, unsigned view). Latency is unchanged.
- `busy` = (state != IDLE).
- `start` while busy is ignored; no queueing.
- MTHI/MTLO:
  - In IDLE without `start`: `hi_we` and `lo_we` write `wd` on the next edge.
  - While busy, or in the same cycle as an accepted `start`: the write is dropped, since `start` has priority.
- `cancel` in CALC or FIX returns to IDLE on the next edge. HI/LO keep their pre-start values and `done` stays low. `cancel` in IDLE has no effect and does not block `start`.
- Reset (`rst`=0 at an edge) sets: state IDLE, busy 0, done 0, hi 0, lo 0, internal accumulators 0. This holds mid-operation too, and overrides `start`, `cancel` and writes.

## Timing
- `start` sampled at edge E0: `busy` goes high after E0.
- Iterations run at edges E1..E32.
- At E33: HI/LO are updated and `done`=1 for exactly the cycle E33..E34; `busy` is already 0 in that cycle.
- Throughput: a new `start` is accepted in the `done` cycle, so back-to-back operations have 33-cycle spacing.
- MTHI/MTLO latency: 1 cycle.
- `hi`/`lo` are driven straight from flops, with no combinational path from inputs.
- `a`, `b` and `op` need only be valid in the `start` cycle.

## Structure
- `mdu_pkg`:
  - op encodings `MDU_MULTU`, `MDU_MULT`, `MDU_DIVU`, `MDU_DIV`;
  - state enum `mdu_state_t` {IDLE, CALC, FIX};
  - `MDU_ITER` = 32.
- One combinational sub-module `mdu_signfix`: takes op, sign flags, the raw 64-bit result and the divide-by-zero flag, and returns the final hi/lo.
- The FSM, the counter and both datapaths live in `mdu`.

## Test plan
- Reset with `rst`=0 for 2 cycles → hi = lo = 0, busy = 0, done = 0; a `start` asserted during reset is ignored.
- MULT a=0xFFFFFFFD (-3), b=7 → done at E0+33 with hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Start MULTU 3×4, then at cycle 5 pulse `start` (DIVU 9/3) plus `hi_we` with wd=0x55 → both ignored; final hi=0, lo=12.
- MTLO 0x1234 in IDLE, then MULT 5×5, then `cancel` at E10 → busy drops after E10, no done, lo stays 0x1234. A following MULT 5×5 gives lo=25 at +33 cycles.
- Reset asserted at E20 of a DIVU → next cycle busy=0, hi=lo=0, and no done ever fires.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM states and iteration count for the multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  // Two's-complement magnitude when neg is set, pass-through otherwise.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
    return neg ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Final sign correction of the unsigned magnitude result into HI/LO.
// Purely combinational; no state, no flow control.
module mdu_signfix
  import mdu_pkg::*;
(
  input  logic [1:0]  op,
  input  logic        sa,
  input  logic        sb,
  input  logic        dz,
  input  logic [63:0] raw,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  always_comb begin
    res_hi = raw[63:32];
    res_lo = raw[31:0];
    if (!op[1]) begin
      if (sa ^ sb) begin
        {res_hi, res_lo} = 64'd0 - raw;
      end
    end else if (dz) begin
      // Divisor zero: remainder register holds |a|; restore a's original bits.
      res_lo = 32'hFFFF_FFFF;
      res_hi = sa ? (32'd0 - raw[63:32]) : raw[63:32];
    end else begin
      if (sa ^ sb) res_lo = 32'd0 - raw[31:0];
      if (sa)      res_hi = 32'd0 - raw[63:32];
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO writes.
// Latency 33 cycles start-to-done; start while busy is dropped (caller stalls on busy).
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t  state, state_nxt;
  logic [5:0]  count;
  logic [1:0]  op_q;
  logic        sa, sb, dz;
  logic [31:0] opa;
  logic [63:0] acc;
  logic [31:0] rem;

  logic        accept, commit;
  logic        sa_in, sb_in;
  logic [31:0] ma, mb;

  assign sa_in = op[0] & a[31];
  assign sb_in = op[0] & b[31];
  assign ma    = mag32(a, sa_in);
  assign mb    = mag32(b, sb_in);

  // Multiply step: conditionally add multiplicand to the upper half, shift right.
  logic [32:0] sum33;
  logic [63:0] acc_mul;
  assign sum33   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
  assign acc_mul = {sum33, acc[31:1]};

  // Divide step: a borrow out of the 33-bit trial subtraction means "no fit".
  logic [32:0] shifted, diff;
  logic        fits;
  logic [31:0] rem_div;
  logic [63:0] acc_div;
  assign shifted = {rem, acc[31]};
  assign diff    = shifted - {1'b0, opa};
  assign fits    = ~diff[32];
  assign rem_div = fits ? diff[31:0] : shifted[31:0];
  assign acc_div = {acc[63:32], acc[30:0], fits};

  logic [63:0] raw;
  logic [31:0] fix_hi, fix_lo;
  assign raw = op_q[1] ? {rem, acc[31:0]} : acc;

  mdu_signfix u_signfix (
    .op     (op_q),
    .sa     (sa),
    .sb     (sb),
    .dz     (dz),
    .raw    (raw),
    .res_hi (fix_hi),
    .res_lo (fix_lo)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cancel)                                state_nxt = IDLE;
        else if (count == 6'(MDU_ITER - 1))        state_nxt = FIX;
      end
      FIX: begin
        commit    = ~cancel;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      op_q  <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dz    <= 1'b0;
      opa   <= '0;
      acc   <= '0;
      rem   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      done  <= commit;
      if (accept) begin
        op_q  <= op;
        sa    <= sa_in;
        sb    <= sb_in;
        dz    <= op[1] & (b == 32'd0);
        count <= '0;
        rem   <= '0;
        if (op[1]) begin
          opa <= mb;
          acc <= {32'd0, ma};
        end else begin
          opa <= ma;
          acc <= {32'd0, mb};
        end
      end else if (state == CALC) begin
        count <= count + 6'd1;
        if (op_q[1]) begin
          acc <= acc_div;
          rem <= rem_div;
        end else begin
          acc <= acc_mul;
        end
      end
      if (commit) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else if (state == IDLE && !start) begin
        if (hi_we) hi <= wd;
        if (lo_we) lo <= wd;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
